arm_mc_controller: RTL and testbench
====================================

# arm_mc_controller

Multicycle control unit for the ARM core. It sequences a shared-ALU, single-memory-port datapath through fetch, decode, execute, memory and writeback states. It decodes the latched instruction into datapath selects and ALU commands, keeps the NZCV condition flags, and gates every architectural write with the instruction's condition field. It sits beside the datapath, which contains the instruction register, the A/WriteData/ALUOut/Data registers, the regfile, the extender and the ALU.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- Instr  in  20  Instr[31:12] from the instruction register:
  - Cond = [31:28]
  - Op = [27:26]
  - Funct = [25:20]
  - Rd = [15:12]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle.
- PCWrite  out  1  PC register load enable.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  regfile write enable.
- IRWrite  out  1  instruction register load enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  1  ALU A operand select: 0 = A register, 1 = PC.
- ALUSrcB  out  2  ALU B operand select: 00 = shifted WriteData, 01 = ExtImm, 10 = constant 4.
- ImmSrc  out  2  equals Op.
- RegSrc  out  2  [0] = (Op==10) selects R15 as RA1; [1] = (Op==01) selects Rd as RA2.
- ALUControl  out  3  ALU command: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR.
- BrL  out  1  forces regfile write address R14 and write data PC.
- State  out  4  current state encoding, for verification.

## Operation
- **State encodings:** FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Unused encodings go to FETCH.
- **FETCH:** IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 (unconditional). Next state is DECODE.
- **DECODE:** ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. CondExReg is captured at this edge. Next state:
  - Op=01 → MEMADR
  - Op=00 with Funct[5]=0 → EXECUTER
  - Op=00 with Funct[5]=1 → EXECUTEI
  - Op=10 → BRANCH
  - Op=11 → FETCH (NOP)
- **MEMADR:** ALUSrcA=0, ALUSrcB=01, ADD. U/B/W bits are ignored. Next state is MEMRD if Funct[0]=1, else MEMWR.
- **MEMRD:** AdrSrc=1. Next state is MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=CondExReg, PCWrite=CondExReg & (Rd==15). Next state is FETCH.
- **MEMWR:** AdrSrc=1, MemWrite=CondExReg. Next state is FETCH.
- **EXECUTER / EXECUTEI:** ALUSrcA=0, ALUSrcB=00 (EXECUTER) or 01 (EXECUTEI), ALUControl from cmd=Funct[4:1]. Next state is ALUWB.
  - cmd 0100 → ADD
  - cmd 0010 → SUB
  - cmd 0000 → AND
  - cmd 1100 → ORR
  - cmd 0001 → EOR
  - cmd 1010 → CMP (SUB, NoWrite, S forced 1)
  - Other cmd values: ADD with NoWrite and no flag update.
- **Flags:** updated at the end of EXECUTER/EXECUTEI when CondExReg & S (Funct[0]) are both set.
  - N and Z are always loaded from ALUFlags.
  - C and V are loaded only for ADD, SUB and CMP.
- **ALUWB:** ResultSrc=00, RegWrite=CondExReg & ~NoWrite, PCWrite=CondExReg & ~NoWrite & (Rd==15). Next state is FETCH.
- **BRANCH:** ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondExReg. Next state is FETCH.
  - If Funct[4] (L) is set: BrL=1 and RegWrite=CondExReg, so R14 receives the already-incremented PC.
- **Outputs outside their states:** write enables are 0. In non-listed states, selects are 0 and ALUControl=000.
- **Condition codes:**
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V
  - GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 false

## Timing
- **Reset:** while reset=1, State=FETCH, flags=0000 and CondExReg=0, and PCWrite, MemWrite, RegWrite and IRWrite are forced to 0. The first FETCH occurs in the first cycle with reset=0.
- **Reset mid-instruction:** state is abandoned at that edge and no further writes occur for that instruction.
- **Output timing:** outputs are a combinational function of State, Instr, CondExReg and the flags register. They are glitch-free relative to clk edges and have no added register latency.
- **Cycles per instruction:** data-processing 4, load 5, store 4, branch 3, Op=11 2.
- **Condition reads:** CondExReg uses the flags value at the DECODE edge. A flag update by an instruction is visible to the next instruction's condition, never its own.
- Instr must be stable from the end of FETCH until the next FETCH; the controller relies on IRWrite for this.

## Test plan
- **Reset then ADD:** reset high for 2 cycles, release, Instr=E0821003 (ADD) → State 0,1,6,8,0. IRWrite=1 in state 0 only. ALUControl=000 in 6. RegWrite=1 only in 8.
- **SUBS then BEQ:** SUBS E2500001 with ALUFlags=0110 in state 7 → flags register=0110. Next instruction BEQ 0A000002 → State 0,1,9 with PCWrite=1 in 9.
- **BNE not taken:** with Z=1, BNE 1A000002 → PCWrite=0 in BRANCH, RegWrite=0, State 0,1,9,0. BL EB000004 (AL) → BrL=1, RegWrite=1, PCWrite=1 in 9.
- **LDR:** E5921004 → State 0,1,2,3,4. AdrSrc=1 in 3. ResultSrc=01 and RegWrite=1 in 4.
- **STR:** E5821004 → MemWrite=1 only in 5. RegWrite=0 throughout.
- **CMP:** E1510002 with ALUFlags=1000 → ALUControl=001, RegWrite=0 in ALUWB, flags register=1000. A following MOVLT-style ADDLT (B0821003) writes.
- **Reset in MEMRD:** reset asserted in state 3 → next State=0, flags=0000, no write enable asserted during reset. Cond=1111 on any instruction → no MemWrite, RegWrite or conditional PCWrite.

Source files
------------

// File: rtl/arm_mc_if.sv
// arm_mc_if: the signal bundle between the multicycle controller and the
// ARM datapath.
//   slave  : the controller. It takes Instr[31:12] and ALUFlags, and drives the
//            write enables, the datapath selects, ALUControl, BrL and State.
//   master : the datapath (or the testbench), with the opposite directions.
interface arm_mc_if;
  logic [19:0] Instr;      // Instr[31:12]
  logic [3:0]  ALUFlags;   // {N,Z,C,V} from the ALU, current cycle
  logic        PCWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [2:0]  ALUControl;
  logic        BrL;
  logic [3:0]  State;

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, BrL, State
  );

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, BrL, State
  );
endinterface

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle control unit for the ARM core. It steps the
// shared-ALU datapath through FETCH, DECODE, EXECUTE, MEM and WB, keeps the
// NZCV flags and gates every architectural write with the condition that was
// latched at DECODE.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : arm_mc_if.slave (Instr and ALUFlags in; controls and State out)
module arm_mc_controller (
  input  logic     clk,
  input  logic     reset,
  arm_mc_if.slave  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;   // {N,Z,C,V}
  logic       cond_q, cond_d;     // CondExReg

  logic [3:0] cond_f;
  logic [1:0] op;
  logic [5:0] funct;
  logic       rd15;
  logic [3:0] cmd;

  assign cond_f = bus.Instr[19:16];
  assign op     = bus.Instr[15:14];
  assign funct  = bus.Instr[13:8];
  assign rd15   = (bus.Instr[3:0] == 4'hF);
  assign cmd    = funct[4:1];

  // Rn is routed by the datapath and is not needed here.
  logic unused_rn;
  assign unused_rn = ^bus.Instr[7:4];

  // Condition evaluation against the flags register, not the live ALU flags.
  logic fn, fz, fc, fv, cond_ok;
  assign {fn, fz, fc, fv} = flags_q;

  always_comb begin
    cond_ok = 1'b0;
    case (cond_f)
      4'h0: cond_ok = fz;
      4'h1: cond_ok = ~fz;
      4'h2: cond_ok = fc;
      4'h3: cond_ok = ~fc;
      4'h4: cond_ok = fn;
      4'h5: cond_ok = ~fn;
      4'h6: cond_ok = fv;
      4'h7: cond_ok = ~fv;
      4'h8: cond_ok = fc & ~fz;
      4'h9: cond_ok = ~fc | fz;
      4'hA: cond_ok = (fn == fv);
      4'hB: cond_ok = (fn != fv);
      4'hC: cond_ok = ~fz & (fn == fv);
      4'hD: cond_ok = fz | (fn != fv);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Data-processing decode. CMP forces S. Unknown commands behave as an ADD
  // that writes nothing and leaves the flags alone.
  logic [2:0] dp_ctl;
  logic       nowrite, s_eff, cv_upd;

  always_comb begin
    dp_ctl  = 3'b000;
    nowrite = 1'b0;
    s_eff   = funct[0];
    cv_upd  = 1'b0;
    case (cmd)
      4'b0100: cv_upd = 1'b1;
      4'b0010: begin dp_ctl = 3'b001; cv_upd = 1'b1; end
      4'b0000: dp_ctl = 3'b010;
      4'b1100: dp_ctl = 3'b011;
      4'b0001: dp_ctl = 3'b100;
      4'b1010: begin dp_ctl = 3'b001; nowrite = 1'b1; s_eff = 1'b1; cv_upd = 1'b1; end
      default: begin nowrite = 1'b1; s_eff = 1'b0; end
    endcase
  end

  // Next state and outputs.
  logic pc_w, mem_w, reg_w, ir_w;

  always_comb begin
    state_d            = FETCH;
    cond_d             = cond_q;
    flags_d            = flags_q;
    pc_w               = 1'b0;
    mem_w              = 1'b0;
    reg_w              = 1'b0;
    ir_w               = 1'b0;
    bus.AdrSrc         = 1'b0;
    bus.ResultSrc      = 2'b00;
    bus.ALUSrcA        = 1'b0;
    bus.ALUSrcB        = 2'b00;
    bus.ALUControl     = 3'b000;
    bus.BrL            = 1'b0;
    case (state_q)
      FETCH: begin
        ir_w          = 1'b1;
        pc_w          = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        state_d       = DECODE;
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        cond_d        = cond_ok;
        case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcB = 2'b01;
        state_d     = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.AdrSrc = 1'b1;
        state_d    = MEMWB;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        reg_w         = cond_q;
        pc_w          = cond_q & rd15;
      end
      MEMWR: begin
        bus.AdrSrc = 1'b1;
        mem_w      = cond_q;
      end
      EXECUTER, EXECUTEI: begin
        bus.ALUSrcB    = (state_q == EXECUTEI) ? 2'b01 : 2'b00;
        bus.ALUControl = dp_ctl;
        state_d        = ALUWB;
        // The flags change at this edge, so the new values are only seen
        // from the next instruction's DECODE onward.
        if (cond_q && s_eff) begin
          flags_d[3:2] = bus.ALUFlags[3:2];
          if (cv_upd) flags_d[1:0] = bus.ALUFlags[1:0];
        end
      end
      ALUWB: begin
        reg_w = cond_q & ~nowrite;
        pc_w  = cond_q & ~nowrite & rd15;
      end
      BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        pc_w          = cond_q;
        if (funct[4]) begin
          bus.BrL = 1'b1;
          reg_w   = cond_q;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // The write enables are masked while reset is held, so no write leaks out
  // during the cycle in which reset is first seen.
  assign bus.PCWrite  = pc_w  & ~reset;
  assign bus.MemWrite = mem_w & ~reset;
  assign bus.RegWrite = reg_w & ~reset;
  assign bus.IRWrite  = ir_w  & ~reset;
  assign bus.ImmSrc   = op;
  assign bus.RegSrc   = {op == 2'b01, op == 2'b10};
  assign bus.State    = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      cond_q  <= cond_d;
    end
  end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller. Each instruction is walked state by
// state. Every expected value is a hand-computed constant.
module tb_arm_mc_controller;
  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  arm_mc_if bus ();

  arm_mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then check State shortly after the edge.
  task automatic step(input string tag, input logic [3:0] exp_state);
    @(posedge clk);
    #1;
    chk({tag, ".state"}, bus.State, exp_state);
  endtask

  // Load a new instruction while the controller is in FETCH.
  task automatic load(input logic [31:0] instr);
    logic [31:0] w;
    w = instr;
    bus.Instr = w[31:12];
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    bus.Instr    = 20'h0;
    bus.ALUFlags = 4'b0000;

    // Reset held for two cycles.
    @(posedge clk); @(posedge clk); #1;
    chk("rst.state", bus.State, 0);
    chk("rst.flags", dut.flags_q, 4'b0000);
    chk("rst.pcw", bus.PCWrite, 0);
    chk("rst.irw", bus.IRWrite, 0);

    // ADD E0821003: 0,1,6,8,0
    reset = 1'b0;
    load(32'hE0821003);
    chk("add.f.irw", bus.IRWrite, 1);
    chk("add.f.pcw", bus.PCWrite, 1);
    chk("add.f.srcb", bus.ALUSrcB, 2'b10);
    chk("add.f.res", bus.ResultSrc, 2'b10);
    step("add.d", 1);
    chk("add.d.irw", bus.IRWrite, 0);
    step("add.e", 6);
    chk("add.e.alu", bus.ALUControl, 3'b000);
    chk("add.e.srcb", bus.ALUSrcB, 2'b00);
    chk("add.e.rw", bus.RegWrite, 0);
    step("add.w", 8);
    chk("add.w.rw", bus.RegWrite, 1);
    chk("add.w.pcw", bus.PCWrite, 0);
    step("add.end", 0);

    // SUBS E2500001 with ALUFlags=0110 in EXECUTEI.
    load(32'hE2500001);
    step("subs.d", 1);
    step("subs.e", 7);
    chk("subs.alu", bus.ALUControl, 3'b001);
    chk("subs.srcb", bus.ALUSrcB, 2'b01);
    bus.ALUFlags = 4'b0110;
    step("subs.w", 8);
    bus.ALUFlags = 4'b0000;
    chk("subs.flags", dut.flags_q, 4'b0110);
    chk("subs.rw", bus.RegWrite, 1);
    step("subs.end", 0);

    // BEQ 0A000002: taken because Z=1.
    load(32'h0A000002);
    step("beq.d", 1);
    step("beq.b", 9);
    chk("beq.pcw", bus.PCWrite, 1);
    chk("beq.rw", bus.RegWrite, 0);
    chk("beq.brl", bus.BrL, 0);
    step("beq.end", 0);

    // BNE 1A000002: not taken.
    load(32'h1A000002);
    step("bne.d", 1);
    step("bne.b", 9);
    chk("bne.pcw", bus.PCWrite, 0);
    chk("bne.rw", bus.RegWrite, 0);
    step("bne.end", 0);

    // BL EB000004
    load(32'hEB000004);
    chk("bl.regsrc", bus.RegSrc, 2'b01);
    step("bl.d", 1);
    step("bl.b", 9);
    chk("bl.brl", bus.BrL, 1);
    chk("bl.rw", bus.RegWrite, 1);
    chk("bl.pcw", bus.PCWrite, 1);
    step("bl.end", 0);

    // LDR E5921004: 0,1,2,3,4
    load(32'hE5921004);
    chk("ldr.imm", bus.ImmSrc, 2'b01);
    step("ldr.d", 1);
    step("ldr.a", 2);
    chk("ldr.a.srca", bus.ALUSrcA, 0);
    chk("ldr.a.srcb", bus.ALUSrcB, 2'b01);
    step("ldr.r", 3);
    chk("ldr.r.adr", bus.AdrSrc, 1);
    chk("ldr.r.rw", bus.RegWrite, 0);
    step("ldr.w", 4);
    chk("ldr.w.res", bus.ResultSrc, 2'b01);
    chk("ldr.w.rw", bus.RegWrite, 1);
    chk("ldr.w.pcw", bus.PCWrite, 0);
    step("ldr.end", 0);

    // LDR into R15: E592F004 also writes the PC.
    load(32'hE592F004);
    step("ldpc.d", 1);
    step("ldpc.a", 2);
    step("ldpc.r", 3);
    step("ldpc.w", 4);
    chk("ldpc.pcw", bus.PCWrite, 1);
    step("ldpc.end", 0);

    // STR E5821004: 0,1,2,5
    load(32'hE5821004);
    step("str.d", 1);
    step("str.a", 2);
    chk("str.a.mw", bus.MemWrite, 0);
    step("str.m", 5);
    chk("str.m.mw", bus.MemWrite, 1);
    chk("str.m.adr", bus.AdrSrc, 1);
    chk("str.m.rw", bus.RegWrite, 0);
    step("str.end", 0);

    // NOP (Op=11) EC000000: 0,1,0
    load(32'hEC000000);
    step("nop.d", 1);
    step("nop.end", 0);

    // CMP E1510002 with ALUFlags=1000.
    load(32'hE1510002);
    step("cmp.d", 1);
    step("cmp.e", 6);
    chk("cmp.alu", bus.ALUControl, 3'b001);
    bus.ALUFlags = 4'b1000;
    step("cmp.w", 8);
    bus.ALUFlags = 4'b0000;
    chk("cmp.rw", bus.RegWrite, 0);
    chk("cmp.flags", dut.flags_q, 4'b1000);
    step("cmp.end", 0);

    // ADDLT B0821003: LT holds with N=1 and V=0.
    load(32'hB0821003);
    step("addlt.d", 1);
    step("addlt.e", 6);
    step("addlt.w", 8);
    chk("addlt.rw", bus.RegWrite, 1);
    step("addlt.end", 0);

    // Cond=1111 never writes.
    load(32'hF0821003);
    step("nvadd.d", 1);
    step("nvadd.e", 6);
    step("nvadd.w", 8);
    chk("nvadd.rw", bus.RegWrite, 0);
    step("nvadd.end", 0);
    load(32'hF5821004);
    step("nvstr.d", 1);
    step("nvstr.a", 2);
    step("nvstr.m", 5);
    chk("nvstr.mw", bus.MemWrite, 0);
    step("nvstr.end", 0);
    load(32'hF592F004);
    step("nvldr.d", 1);
    step("nvldr.a", 2);
    step("nvldr.r", 3);
    step("nvldr.w", 4);
    chk("nvldr.rw", bus.RegWrite, 0);
    chk("nvldr.pcw", bus.PCWrite, 0);
    step("nvldr.end", 0);

    // Reset raised in MEMRD. The flags are still 1000 from the CMP.
    load(32'hE5921004);
    step("rld.d", 1);
    step("rld.a", 2);
    step("rld.r", 3);
    reset = 1'b1;
    #1;
    chk("rld.r.rw", bus.RegWrite, 0);
    step("rld.rst", 0);
    chk("rld.flags", dut.flags_q, 4'b0000);
    chk("rld.pcw", bus.PCWrite, 0);
    chk("rld.irw", bus.IRWrite, 0);
    chk("rld.mw", bus.MemWrite, 0);
    reset = 1'b0;
    #1;
    chk("rld.rel.irw", bus.IRWrite, 1);
    step("rld.rel.d", 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
